alu_exec_stage: RTL and testbench

//  Registered RISC-V execute stage: ALU control decode, 32-bit ALU with zero flag,
//  and the two PC adders (PC+4, PC+imm branch target).

---
 rtl/alu_exec_stage.sv | 179 +++++++++++++++++
 tb/tb_alu_exec_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
// ----------------------------------------------------------------------------
// Registered RISC-V execute stage. It decodes ALUOp/funct3 into a 4-bit
// ALUControl code, runs the 32-bit ALU, and computes PC+4 and the PC+imm
// branch target. All results are captured in output registers, so the
// latency is one cycle. There is no backpressure, so an operation can be
// accepted every cycle.
//
// Optional feature macro: ALU_OVERFLOW_EN
//   When defined, the stage adds overflow_o, a registered signed-overflow
//   flag for ADD and SUB.
//
// Ports
//   clk_i             clock; all state updates on its rising edge
//   rst_ni            asynchronous, active-low reset
//   in_valid_i        operands, pc and imm are valid this cycle
//   alu_op_i   [2:0]  ALUOp from main control
//   funct3_i   [2:0]  instruction[14:12]
//   op_a_i     [XLEN] readData1
//   op_b_i     [XLEN] ALUSrc-muxed operand (readData2 or imm)
//   pc_i       [XLEN] current program counter
//   imm_i      [XLEN] sign-extended immediate
//   out_valid_o       registered copy of in_valid_i
//   alu_ctrl_o [3:0]  registered ALUControl code (debug/trace)
//   alu_result_o      registered ALU result
//   zero_o            registered (alu_result == 0)
//   pc_plus4_o        registered pc + PC_STEP
//   branch_target_o   registered pc + imm
//   overflow_o        registered signed overflow (ALU_OVERFLOW_EN only)
// ----------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  input  logic [2:0]      alu_op_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            out_valid_o,
  output logic [3:0]      alu_ctrl_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic            zero_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] branch_target_o
`ifdef ALU_OVERFLOW_EN
  ,
  output logic            overflow_o
`endif
);

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlXor = 4'b0011;
  localparam logic [3:0] CtrlSll = 4'b0100;
  localparam logic [3:0] CtrlSrl = 4'b0101;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlSlt = 4'b0111;

  localparam logic [XLEN-1:0] PcStep = XLEN'(PC_STEP);

  logic [3:0]      alu_ctrl_d,      alu_ctrl_q;
  logic [XLEN-1:0] alu_result_d,    alu_result_q;
  logic            zero_d,          zero_q;
  logic [XLEN-1:0] pc_plus4_d,      pc_plus4_q;
  logic [XLEN-1:0] branch_target_d, branch_target_q;
  logic            out_valid_q;
  logic [3:0]      funct3_ctrl;

  // R/I-type funct3 map. alu_op 011 reuses it for everything except funct3 000.
  always_comb begin
    funct3_ctrl = CtrlAdd;
    case (funct3_i)
      3'b000:  funct3_ctrl = CtrlAdd;
      3'b001:  funct3_ctrl = CtrlSll;
      3'b010:  funct3_ctrl = CtrlSlt;
      3'b011:  funct3_ctrl = CtrlAdd;
      3'b100:  funct3_ctrl = CtrlXor;
      3'b101:  funct3_ctrl = CtrlSrl;
      3'b110:  funct3_ctrl = CtrlOr;
      3'b111:  funct3_ctrl = CtrlAnd;
      default: funct3_ctrl = CtrlAdd;
    endcase
  end

  always_comb begin
    alu_ctrl_d = CtrlAdd;
    case (alu_op_i)
      3'b000:  alu_ctrl_d = CtrlAdd;
      3'b001:  alu_ctrl_d = CtrlSub;
      3'b010:  alu_ctrl_d = funct3_ctrl;
      3'b011:  alu_ctrl_d = (funct3_i == 3'b000) ? CtrlSub : funct3_ctrl;
      default: alu_ctrl_d = CtrlAdd;
    endcase
  end

  always_comb begin
    alu_result_d = '0;
    case (alu_ctrl_d)
      CtrlAnd: alu_result_d = op_a_i & op_b_i;
      CtrlOr:  alu_result_d = op_a_i | op_b_i;
      CtrlAdd: alu_result_d = op_a_i + op_b_i;
      CtrlSub: alu_result_d = op_a_i - op_b_i;
      CtrlXor: alu_result_d = op_a_i ^ op_b_i;
      CtrlSll: alu_result_d = op_a_i << op_b_i[4:0];
      CtrlSrl: alu_result_d = op_a_i >> op_b_i[4:0];
      CtrlSlt: alu_result_d = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      default: alu_result_d = '0;
    endcase
  end

  assign zero_d          = (alu_result_d == '0);
  assign pc_plus4_d      = pc_i + PcStep;
  assign branch_target_d = pc_i + imm_i;

  // Result registers only load on valid input; out_valid follows in_valid every edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q     <= 1'b0;
      alu_ctrl_q      <= '0;
      alu_result_q    <= '0;
      zero_q          <= 1'b0;
      pc_plus4_q      <= '0;
      branch_target_q <= '0;
    end else begin
      out_valid_q <= in_valid_i;
      if (in_valid_i) begin
        alu_ctrl_q      <= alu_ctrl_d;
        alu_result_q    <= alu_result_d;
        zero_q          <= zero_d;
        pc_plus4_q      <= pc_plus4_d;
        branch_target_q <= branch_target_d;
      end
    end
  end

  assign out_valid_o     = out_valid_q;
  assign alu_ctrl_o      = alu_ctrl_q;
  assign alu_result_o    = alu_result_q;
  assign zero_o          = zero_q;
  assign pc_plus4_o      = pc_plus4_q;
  assign branch_target_o = branch_target_q;

`ifdef ALU_OVERFLOW_EN
  logic overflow_d, overflow_q;
  logic sign_a, sign_b, sign_r;

  assign sign_a = op_a_i[XLEN-1];
  assign sign_b = op_b_i[XLEN-1];
  assign sign_r = alu_result_d[XLEN-1];

  // ADD overflows when like-signed operands give an opposite-signed result;
  // SUB overflows when operands differ in sign and the result's sign flips from op_a.
  always_comb begin
    overflow_d = 1'b0;
    case (alu_ctrl_d)
      CtrlAdd: overflow_d = (sign_a == sign_b) && (sign_r != sign_a);
      CtrlSub: overflow_d = (sign_a != sign_b) && (sign_r != sign_a);
      default: overflow_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
    end else if (in_valid_i) begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage
// ----------------------------------------------------------------------------
// Self-checking bench for alu_exec_stage. Directed cases cover reset,
// decode, shifts, SLT, PC wrap-around and hold; a randomized run is checked
// against a behavioural model that works from operation names and plain
// integer arithmetic. Define ALU_OVERFLOW_EN to also exercise overflow_o.
// ----------------------------------------------------------------------------
module tb_alu_exec_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic [2:0]  alu_op_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  logic        out_valid_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_o;
  logic        zero_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] branch_target_o;
`ifdef ALU_OVERFLOW_EN
  logic        overflow_o;
`endif

  int assertCount = 0;
  int failCount   = 0;

  // Expected register contents, maintained by the model
  logic        expValid;
  logic [3:0]  expCtrl;
  logic [31:0] expResult;
  logic        expZero;
  logic [31:0] expPc4;
  logic [31:0] expTarget;
  logic        expOverflow;

  alu_exec_stage #(.XLEN(32), .PC_STEP(4)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .in_valid_i      (in_valid_i),
    .alu_op_i        (alu_op_i),
    .funct3_i        (funct3_i),
    .op_a_i          (op_a_i),
    .op_b_i          (op_b_i),
    .pc_i            (pc_i),
    .imm_i           (imm_i),
    .out_valid_o     (out_valid_o),
    .alu_ctrl_o      (alu_ctrl_o),
    .alu_result_o    (alu_result_o),
    .zero_o          (zero_o),
    .pc_plus4_o      (pc_plus4_o),
    .branch_target_o (branch_target_o)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow_o      (overflow_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Work out which operation the instruction asks for, then evaluate it
  // with ordinary integer arithmetic.
  function automatic string opName(input logic [2:0] aluOp, input logic [2:0] f3);
    string kind;
    if (aluOp[2] || aluOp == 3'b000)        kind = "add";
    else if (aluOp == 3'b001)               kind = "sub";
    else if (aluOp == 3'b011 && f3 == 3'd0) kind = "sub";
    else begin
      case (f3)
        3'd1:    kind = "sll";
        3'd2:    kind = "slt";
        3'd4:    kind = "xor";
        3'd5:    kind = "srl";
        3'd6:    kind = "or";
        3'd7:    kind = "and";
        default: kind = "add";
      endcase
    end
    return kind;
  endfunction

  task automatic refModel(input logic [2:0] aluOp, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [3:0] ctrl, output logic [31:0] res,
                          output logic ov);
    string  kind;
    longint sa, sb, wide;
    kind = opName(aluOp, f3);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ov   = 1'b0;
    case (kind)
      "add": begin
        ctrl = 4'd2; wide = sa + sb; res = wide[31:0];
        ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      "sub": begin
        ctrl = 4'd6; wide = sa - sb; res = wide[31:0];
        ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      "and": begin ctrl = 4'd0; res = a & b; end
      "or":  begin ctrl = 4'd1; res = a | b; end
      "xor": begin ctrl = 4'd3; res = a ^ b; end
      "sll": begin ctrl = 4'd4; res = 32'((64'(a) * (64'd1 << b[4:0])) & 64'hFFFF_FFFF); end
      "srl": begin ctrl = 4'd5; res = 32'(64'(a) / (64'd1 << b[4:0])); end
      default: begin ctrl = 4'd7; res = (sa < sb) ? 32'd1 : 32'd0; end
    endcase
  endtask

  task automatic modelReset();
    expValid = 0; expCtrl = 0; expResult = 0; expZero = 0;
    expPc4 = 0; expTarget = 0; expOverflow = 0;
  endtask

  task automatic checkField(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
  endtask

  task automatic checkOutput(input string step);
    checkField({step, ".out_valid"}, 32'(out_valid_o), 32'(expValid));
    checkField({step, ".alu_ctrl"}, 32'(alu_ctrl_o), 32'(expCtrl));
    checkField({step, ".alu_result"}, alu_result_o, expResult);
    checkField({step, ".zero"}, 32'(zero_o), 32'(expZero));
    checkField({step, ".pc_plus4"}, pc_plus4_o, expPc4);
    checkField({step, ".branch_target"}, branch_target_o, expTarget);
`ifdef ALU_OVERFLOW_EN
    checkField({step, ".overflow"}, 32'(overflow_o), 32'(expOverflow));
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge
  // capture them, then update the model and sample 1 ns later.
  task automatic applyStimulus(input logic v, input logic [2:0] aluOp, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] imm);
    logic [3:0]  c;
    logic [31:0] r;
    logic        o;
    @(negedge clk_i);
    in_valid_i = v; alu_op_i = aluOp; funct3_i = f3;
    op_a_i = a; op_b_i = b; pc_i = pc; imm_i = imm;
    @(posedge clk_i);
    #1;
    expValid = v;
    if (v) begin
      refModel(aluOp, f3, a, b, c, r, o);
      expCtrl = c; expResult = r; expZero = (r == 32'd0);
      expPc4 = pc + 32'd4; expTarget = pc + imm; expOverflow = o;
    end
  endtask

  initial begin
    logic [31:0] a, b;

    rst_ni = 1'b0; in_valid_i = 1'b0; alu_op_i = '0; funct3_i = '0;
    op_a_i = '0; op_b_i = '0; pc_i = '0; imm_i = '0;
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Load address: 100 + (-4)
    applyStimulus(1, 3'b000, 3'b000, 32'd100, 32'hFFFF_FFFC, 32'h100, 32'h20);
    checkOutput("add_load");
    checkField("add_load.const_result", alu_result_o, 32'd96);
    checkField("add_load.const_ctrl", 32'(alu_ctrl_o), 32'b0010);

    // Branch compare of equal values
    applyStimulus(1, 3'b001, 3'b000, 32'h1234, 32'h1234, 32'h200, 32'hFFFF_FFF0);
    checkOutput("sub_branch");
    checkField("sub_branch.const_zero", 32'(zero_o), 32'd1);
    checkField("sub_branch.const_ctrl", 32'(alu_ctrl_o), 32'b0110);

    // Signed SLT: -1 < 1
    applyStimulus(1, 3'b010, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h4);
    checkOutput("slt");
    checkField("slt.const_result", alu_result_o, 32'd1);

    // Logical shift right fills with zeros
    applyStimulus(1, 3'b010, 3'b101, 32'h8000_0000, 32'd31, 32'h304, 32'h4);
    checkOutput("srl");
    checkField("srl.const_result", alu_result_o, 32'd1);

    // alu_op 011: funct3 000 is SUB, others follow the funct3 map
    applyStimulus(1, 3'b011, 3'b000, 32'd10, 32'd3, 32'h308, 32'h0);
    checkOutput("op011_sub");
    applyStimulus(1, 3'b011, 3'b110, 32'hF0F0_0000, 32'h0000_0F0F, 32'h30C, 32'h0);
    checkOutput("op011_or");
    applyStimulus(1, 3'b110, 3'b111, 32'd7, 32'd8, 32'h310, 32'h0);
    checkOutput("op1xx_add");

    // PC wrap-around
    applyStimulus(1, 3'b000, 3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8);
    checkOutput("pc_wrap");
    checkField("pc_wrap.const_pc4", pc_plus4_o, 32'd0);
    checkField("pc_wrap.const_target", branch_target_o, 32'd4);

    // Invalid input: results hold, out_valid drops
    applyStimulus(0, 3'b001, 3'b000, 32'd55, 32'd1, 32'h1000, 32'h40);
    checkOutput("hold");

`ifdef ALU_OVERFLOW_EN
    applyStimulus(1, 3'b000, 3'b000, 32'h7FFF_FFFF, 32'd1, 32'h0, 32'h0);
    checkOutput("ovf_add");
    checkField("ovf_add.const_flag", 32'(overflow_o), 32'd1);
    applyStimulus(1, 3'b001, 3'b000, 32'd5, 32'd3, 32'h0, 32'h0);
    checkOutput("ovf_sub");
    checkField("ovf_sub.const_result", alu_result_o, 32'd2);
`endif

    // Randomized run against the model
    for (int i = 0; i < 300; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 7) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) b = {27'd0, b[4:0]};
      applyStimulus($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), a, b, $urandom(), $urandom());
      checkOutput($sformatf("rand%0d", i));
    end

    // Asynchronous reset mid-stream with valid data present
    applyStimulus(1, 3'b010, 3'b100, 32'hDEAD_BEEF, 32'h1234_5678, 32'h40, 32'h80);
    #2;
    rst_ni = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(1, 3'b010, 3'b001, 32'h0000_0003, 32'd4, 32'h80, 32'h10);
    checkOutput("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
